// File: rtl/neuron_mac.sv
// neuron_mac: serial multiply-accumulate for one MLP neuron with local weight/bias storage.
// One activation per handshake in ACC; bias added in BIAS; result pulses out_valid in DONE.
module neuron_mac #(
    parameter int BITS       = 32,
    parameter int NUM_INPUTS = 3,
    parameter int W_BITS     = 16,
    parameter int B_BITS     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [BITS-1:0]   x_in,
    input  logic                     w_we,
    input  logic [7:0]               w_addr,
    input  logic signed [W_BITS-1:0] w_data,
    input  logic                     bias_we,
    input  logic signed [B_BITS-1:0] bias_data,
    output logic [BITS+24:0]         mult_sum_out,
    output logic [31:0]              counter,
    output logic                     out_valid
);
    localparam int OW = BITS + 25;
    localparam int PW = BITS + W_BITS;
    localparam int AW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic [1:0] {IDLE, ACC, BIAS, DONE} state_t;

    state_t                    state_q, state_d;
    logic [OW-1:0]             acc_q, acc_d, sum_q, sum_d;
    logic [31:0]               cnt_q, cnt_d;
    logic signed [W_BITS-1:0]  w_q [NUM_INPUTS];
    logic signed [B_BITS-1:0]  bias_q;
    logic signed [W_BITS-1:0]  w_sel;
    logic signed [PW-1:0]      prod;
    logic                      idle;

    assign idle         = state_q == IDLE;
    assign in_ready     = state_q == ACC;
    assign out_valid    = state_q == DONE;
    assign mult_sum_out = sum_q;
    assign counter      = cnt_q;
    assign w_sel        = cnt_q < 32'(NUM_INPUTS) ? w_q[cnt_q[AW-1:0]] : '0;
    assign prod         = x_in * w_sel;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = ACC;
                acc_d   = '0;
                cnt_d   = '0;
            end
            ACC: if (in_valid) begin
                acc_d   = acc_q + {{(OW-PW){prod[PW-1]}}, prod};
                cnt_d   = cnt_q + 32'd1;
                state_d = cnt_q == 32'(NUM_INPUTS - 1) ? BIAS : ACC;
            end
            BIAS: begin
                sum_d   = acc_q + {{(OW-B_BITS){bias_q[B_BITS-1]}}, bias_q};
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is writable only in IDLE; out-of-range addresses match no slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) w_q[i] <= '0;
        end else if (idle) begin
            if (bias_we) bias_q <= bias_data;
            for (int i = 0; i < NUM_INPUTS; i++)
                if (w_we && w_addr == 8'(i)) w_q[i] <= w_data;
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed checks of neuron_mac with hand-computed sums and latencies.
module tb_neuron_mac;
    logic               clk = 0;
    logic               rst = 1;
    logic               start = 0, in_valid = 0, w_we = 0, bias_we = 0;
    logic               in_ready, out_valid;
    logic signed [31:0] x_in = 0;
    logic [7:0]         w_addr = 0;
    logic signed [15:0] w_data = 0;
    logic signed [31:0] bias_data = 0;
    logic [56:0]        mult_sum_out;
    logic [31:0]        counter;
    int                 checks = 0, failures = 0;

    neuron_mac dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .bias_we(bias_we),
        .bias_data(bias_data), .mult_sum_out(mult_sum_out), .counter(counter),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [56:0] got, input logic [56:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic signed [15:0] d,
                      input logic be, input logic signed [31:0] b);
        w_we = 1; w_addr = a; w_data = d; bias_we = be; bias_data = b;
        tick();
        w_we = 0; bias_we = 0;
    endtask

    task automatic load(input logic signed [15:0] w0, w1, w2, input logic signed [31:0] b);
        wr(8'd0, w0, 1'b1, b);
        wr(8'd1, w1, 1'b0, 0);
        wr(8'd2, w2, 1'b0, 0);
    endtask

    task automatic run_pass(input string tag, input logic signed [31:0] x0, x1, x2,
                            input int gap, input logic sw, input logic [7:0] sa,
                            input logic signed [15:0] sd, input logic [56:0] exp_sum,
                            input int exp_lat);
        logic signed [31:0] xs [3];
        int cyc;
        xs = '{x0, x1, x2};
        start = 1; w_we = sw; w_addr = sa; w_data = sd;
        tick();
        start = 0; w_we = 0; cyc = 1;
        check({tag, " in_ready"}, 57'(in_ready), 57'd1);
        for (int i = 0; i < 3; i++) begin
            repeat (i > 0 ? gap : 0) begin
                in_valid = 0; tick(); cyc++;
            end
            check({tag, " counter"}, 57'(counter), 57'(i));
            in_valid = 1; x_in = xs[i];
            tick(); cyc++;
        end
        in_valid = 0;
        check({tag, " bias ready"}, 57'(in_ready), 57'd0);
        while (!out_valid && cyc < 100) begin
            tick(); cyc++;
        end
        check({tag, " latency"}, 57'(cyc), 57'(exp_lat));
        check({tag, " out_valid"}, 57'(out_valid), 57'd1);
        check({tag, " sum"}, mult_sum_out, exp_sum);
        check({tag, " count"}, 57'(counter), 57'd3);
        tick();
        check({tag, " pulse"}, 57'(out_valid), 57'd0);
        check({tag, " hold"}, mult_sum_out, exp_sum);
    endtask

    initial begin
        logic ov_seen;
        int cyc;
        repeat (2) tick();
        check("rst sum", mult_sum_out, 57'd0);
        check("rst cnt", 57'(counter), 57'd0);
        check("rst ready", 57'(in_ready), 57'd0);
        check("rst valid", 57'(out_valid), 57'd0);
        rst = 0;
        tick();

        load(2, -3, 5, 10);
        wr(8'd4, 16'sd99, 1'b0, 0);
        wr(8'd3, 16'sd77, 1'b0, 0);
        check("idle ready", 57'(in_ready), 57'd0);
        run_pass("basic", 4, 1, -2, 0, 1'b0, 8'd0, 0, 57'd5, 5);

        load(2, 9, 5, -5);
        run_pass("neg", 0, 10, 0, 0, 1'b1, 8'd1, -3, -57'sd35, 5);
        check("neg msb", 57'(mult_sum_out[56]), 57'd1);

        load(2, -3, 5, 10);
        run_pass("stall", 4, 1, -2, 4, 1'b0, 8'd0, 0, 57'd5, 13);

        in_valid = 1; x_in = 7;
        repeat (2) tick();
        in_valid = 0;
        check("idle in_valid cnt", 57'(counter), 57'd3);

        load(-16'sd32768, -16'sd32768, -16'sd32768, 32'sh7FFFFFFF);
        run_pass("extreme", 32'sh80000000, 32'sh80000000, 32'sh80000000, 0, 1'b0, 8'd0, 0,
                 (57'd3 << 46) + 57'h7FFFFFFF, 5);

        load(2, -3, 5, 10);
        start = 1; tick(); start = 0;
        in_valid = 1; x_in = 4; tick();
        in_valid = 0; start = 1;
        w_we = 1; w_addr = 1; w_data = 100; bias_we = 1; bias_data = 1000;
        tick();
        start = 0; w_we = 0; bias_we = 0;
        check("ign cnt", 57'(counter), 57'd1);
        in_valid = 1; x_in = 1; tick();
        x_in = -2; tick();
        in_valid = 0; cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick(); cyc++;
        end
        check("ign valid", 57'(out_valid), 57'd1);
        check("ign sum", mult_sum_out, 57'd5);
        tick();

        start = 1; tick(); start = 0;
        in_valid = 1; x_in = 4; tick();
        x_in = 1; tick();
        in_valid = 0;
        check("mid cnt", 57'(counter), 57'd2);
        #2 rst = 1;
        #1;
        check("abort cnt", 57'(counter), 57'd0);
        check("abort sum", mult_sum_out, 57'd0);
        check("abort ready", 57'(in_ready), 57'd0);
        check("abort valid", 57'(out_valid), 57'd0);
        ov_seen = 0;
        repeat (2) begin
            tick(); ov_seen |= out_valid;
        end
        rst = 0;
        repeat (5) begin
            tick(); ov_seen |= out_valid;
        end
        check("abort no valid", 57'(ov_seen), 57'd0);
        run_pass("lost", 4, 1, -2, 0, 1'b0, 8'd0, 0, 57'd0, 5);
        load(2, -3, 5, 10);
        run_pass("reload", 4, 1, -2, 0, 1'b0, 8'd0, 0, 57'd5, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
